// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPE142 multicycle control path: opcodes, FSM states,
// mux selects and ALU operations. muxA, muxB and the ALU use the same constants.
package cpu_ctrl_pkg;

  localparam int OP_W    = 4;
  localparam int ALUOP_W = 3;
  localparam int DATA_W  = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_BRANCH,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic       SEL_A_REG = 1'b0;
  localparam logic       SEL_A_PC  = 1'b1;

  localparam logic [1:0] SEL_B_RT  = 2'd0;
  localparam logic [1:0] SEL_B_IMM = 2'd1;
  localparam logic [1:0] SEL_B_TWO = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  typedef struct packed {
    logic is_rtype;
    logic is_imm;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_halt;
    logic is_illegal;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier feeding the control FSM.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] ir_op,
  output dec_t            dec
);

  always_comb begin
    dec = '0;
    case (ir_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: dec.is_rtype = 1'b1;
      OP_ADDI:                       dec.is_imm   = 1'b1;
      OP_LW:                         dec.is_lw    = 1'b1;
      OP_SW:                         dec.is_sw    = 1'b1;
      OP_BEQ:                        dec.is_beq   = 1'b1;
      OP_HALT:                       dec.is_halt  = 1'b1;
      default:                       dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl_fsm.sv
// Multicycle fetch/decode/execute/mem/writeback controller for the 16-bit datapath.
// Optional retired-instruction counter enabled by defining CTRL_PERF_CNT_EN.
module datapath_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [OP_W-1:0]    ir_op,
  input  logic               alu_zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               sel_a,
  output logic [1:0]         sel_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               ir_we,
  output logic               pc_we,
  output logic               reg_we,
  output logic               wb_sel,
  output logic               busy,
  output logic               halted,
`ifdef CTRL_PERF_CNT_EN
  output logic [15:0]        retired,
`endif
  output logic               illegal
);

  state_t     state, state_n;
  dec_t       dec;
  logic [2:0] alu_n;

  ctrl_decode #(.OP_W(OP_W)) u_dec (
    .ir_op (ir_op),
    .dec   (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    sel_a   = SEL_A_REG;
    sel_b   = SEL_B_RT;
    alu_n   = ALU_ADD;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    reg_we  = 1'b0;
    wb_sel  = 1'b0;
    busy    = 1'b1;
    halted  = 1'b0;
    illegal = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (run) state_n = ST_FETCH;
      end
      ST_FETCH: begin
        // ALU computes PC+2 while the instruction word is read
        mem_req = 1'b1;
        sel_a   = SEL_A_PC;
        sel_b   = SEL_B_TWO;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_n = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.is_halt) begin
          state_n = ST_HALT;
        end else if (dec.is_illegal) begin
          illegal = 1'b1;
          state_n = ST_FETCH;
        end else begin
          state_n = ST_EXEC;
        end
      end
      ST_EXEC: begin
        sel_a = SEL_A_REG;
        if (dec.is_imm || dec.is_lw || dec.is_sw) begin
          sel_b = SEL_B_IMM;
          alu_n = ALU_ADD;
        end else if (dec.is_beq) begin
          alu_n = ALU_SUB;
        end else begin
          case (ir_op)
            OP_SUB:  alu_n = ALU_SUB;
            OP_AND:  alu_n = ALU_AND;
            OP_OR:   alu_n = ALU_OR;
            default: alu_n = ALU_ADD;
          endcase
        end
        if (dec.is_lw || dec.is_sw) state_n = ST_MEM;
        else if (dec.is_beq)        state_n = alu_zero ? ST_BRANCH : ST_FETCH;
        else                        state_n = ST_WB;
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = dec.is_sw;
        if (mem_ack) state_n = dec.is_lw ? ST_WB : ST_FETCH;
      end
      ST_BRANCH: begin
        // PC already holds PC+2, so the target is PC + sext(imm)
        sel_a   = SEL_A_PC;
        sel_b   = SEL_B_IMM;
        alu_n   = ALU_ADD;
        pc_we   = 1'b1;
        state_n = ST_FETCH;
      end
      ST_WB: begin
        reg_we  = 1'b1;
        wb_sel  = dec.is_lw;
        state_n = ST_FETCH;
      end
      ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: begin
        busy    = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  assign alu_op = ALUOP_W'(alu_n);

`ifdef CTRL_PERF_CNT_EN
  // Every return to FETCH except the initial start from IDLE closes an instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retired <= '0;
    else if (state != ST_IDLE && state != ST_FETCH && state_n == ST_FETCH)
      retired <= retired + 16'd1;
  end
`endif

endmodule
